fifo2core: RTL and testbench

- Core-clock end of the APB command/status path. Runs in the transceiver clock domain. Sits between the two async FIFOs and the SL transceiver core.
- Downlink: pops {modifier, data} command words written by the APB bridge, decodes them, and drives the core's config register, channel register and transmit-data handshake.
- Uplink: pushes received data, status changes, and config/channel echoes back as {modifier, data} words, so the APB-side shadow registers track the core.

---
 rtl/fifo2core.sv | 235 +++++++++++++++++++++++
 tb/tb_fifo2core.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo2core.sv
// rtl/fifo2core.sv - core-clock end of the command/status FIFO path
//
// Downlink: pops {modifier, data} command words from the downlink FIFO and
// applies them to the core (config register, channel register, transmit
// handshake, write-1-to-clear of the overrun flag).
// Uplink: pushes status changes, received words and config/channel echoes
// back as {modifier, data} words so the bus-side shadow registers track the core.
//
// Ports:
//   clk, rst                   core clock, synchronous active-high reset
//   fifo_read_empty/data/inc   downlink FIFO (first-word fall-through) and pop strobe
//   fifo_write_full/data/inc   uplink FIFO full flag, pushed word and push strobe
//   config_out, channel_out    core configuration and channel select registers
//   tx_data/tx_valid/tx_ready  transmit-data handshake to the core
//   rx_data/rx_valid           received word and its one-cycle strobe
//   status_in                  live core status (top bit ignored)
//   rx_overrun                 sticky flag: a received word was lost

module fifo2core #(
    parameter int          CONFIG_REG_WIDTH  = 16,
    parameter int          STATUS_REG_WIDTH  = 16,
    parameter int          CHANNEL_REG_WIDTH = 2,
    parameter logic [1:0]  CONFIG_MODIFIER   = 2'd0,
    parameter logic [1:0]  DATA_MODIFIER     = 2'd1,
    parameter logic [1:0]  STATUS_MODIFIER   = 2'd2,
    parameter logic [1:0]  CHANNEL_MODIFIER  = 2'd3
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         fifo_read_empty,
    input  logic [33:0]                  fifo_read_data,
    output logic                         fifo_read_inc,
    input  logic                         fifo_write_full,
    output logic [33:0]                  fifo_write_data,
    output logic                         fifo_write_inc,
    output logic [CONFIG_REG_WIDTH-1:0]  config_out,
    output logic [CHANNEL_REG_WIDTH-1:0] channel_out,
    output logic [31:0]                  tx_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    input  logic [31:0]                  rx_data,
    input  logic                         rx_valid,
    input  logic [STATUS_REG_WIDTH-1:0]  status_in,
    output logic                         rx_overrun
);

    typedef enum logic [2:0] {
        IDLE    = 3'b001,
        EXEC    = 3'b010,
        WAIT_TX = 3'b100
    } state_t;

    state_t state;
    state_t state_next;

    logic [33:0] cmd_r;
    logic [1:0]  cmd_mod;

    // Downlink control strobes decoded from the FSM
    logic pop;
    logic ld_cfg;
    logic ld_ch;
    logic ld_tx;
    logic clr_tx;
    logic clr_ovr;

    // Uplink state
    logic [STATUS_REG_WIDTH-1:0] last_status;
    logic [STATUS_REG_WIDTH-1:0] stat_word;
    logic                        status_diff;
    logic                        status_pend;
    logic                        rx_pend;
    logic [31:0]                 rx_hold;
    logic                        cfg_echo_pend;
    logic                        ch_echo_pend;

    logic        srv_stat;
    logic        srv_rx;
    logic        srv_cfg;
    logic        srv_ch;
    logic        push;
    logic [33:0] push_word;

    // The top status bit is replaced by rx_overrun in the uplink word.
    logic status_msb_unused;
    assign status_msb_unused = status_in[STATUS_REG_WIDTH-1];

    assign cmd_mod = cmd_r[33:32];

    // ------------------------------------------------------------------
    // Downlink FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        ld_cfg     = 1'b0;
        ld_ch      = 1'b0;
        ld_tx      = 1'b0;
        clr_tx     = 1'b0;
        clr_ovr    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_read_empty) begin
                    pop        = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = IDLE;
                if (cmd_mod == CONFIG_MODIFIER) begin
                    ld_cfg = 1'b1;
                end else if (cmd_mod == CHANNEL_MODIFIER) begin
                    ld_ch = 1'b1;
                end else if (cmd_mod == DATA_MODIFIER) begin
                    ld_tx      = 1'b1;
                    state_next = WAIT_TX;
                end else if (cmd_mod == STATUS_MODIFIER) begin
                    clr_ovr = cmd_r[15];
                end
            end
            WAIT_TX: begin
                if (tx_ready) begin
                    clr_tx     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Uplink arbitration: status > rx data > config echo > channel echo
    // ------------------------------------------------------------------
    assign stat_word   = {rx_overrun, status_in[STATUS_REG_WIDTH-2:0]};
    assign status_diff = (stat_word != last_status);

    assign srv_stat = !fifo_write_full && status_pend;
    assign srv_rx   = !fifo_write_full && !status_pend && rx_pend;
    assign srv_cfg  = !fifo_write_full && !status_pend && !rx_pend && cfg_echo_pend;
    assign srv_ch   = !fifo_write_full && !status_pend && !rx_pend && !cfg_echo_pend
                      && ch_echo_pend;
    assign push     = srv_stat || srv_rx || srv_cfg || srv_ch;

    always_comb begin
        push_word = '0;
        if (srv_stat) begin
            push_word = {STATUS_MODIFIER, 32'(stat_word)};
        end else if (srv_rx) begin
            push_word = {DATA_MODIFIER, rx_hold};
        end else if (srv_cfg) begin
            push_word = {CONFIG_MODIFIER, 32'(config_out)};
        end else if (srv_ch) begin
            push_word = {CHANNEL_MODIFIER, 32'(channel_out)};
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_r           <= '0;
            fifo_read_inc   <= 1'b0;
            config_out      <= '0;
            channel_out     <= '0;
            tx_data         <= '0;
            tx_valid        <= 1'b0;
            rx_overrun      <= 1'b0;
            rx_hold         <= '0;
            rx_pend         <= 1'b0;
            status_pend     <= 1'b0;
            last_status     <= '0;
            cfg_echo_pend   <= 1'b0;
            ch_echo_pend    <= 1'b0;
            fifo_write_data <= '0;
            fifo_write_inc  <= 1'b0;
        end else begin
            fifo_read_inc <= pop;
            if (pop) begin
                cmd_r <= fifo_read_data;
            end

            if (ld_cfg) begin
                config_out <= cmd_r[CONFIG_REG_WIDTH-1:0];
            end
            if (ld_ch) begin
                channel_out <= cmd_r[CHANNEL_REG_WIDTH-1:0];
            end
            if (ld_tx) begin
                tx_data  <= cmd_r[31:0];
                tx_valid <= 1'b1;
            end else if (clr_tx) begin
                tx_valid <= 1'b0;
            end

            // A new word landing on an unserved one loses the old word; the
            // set takes priority over a same-cycle software clear.
            if (rx_valid) begin
                rx_hold <= rx_data;
            end
            rx_pend <= rx_valid || (rx_pend && !srv_rx);
            if (rx_valid && rx_pend && !srv_rx) begin
                rx_overrun <= 1'b1;
            end else if (clr_ovr) begin
                rx_overrun <= 1'b0;
            end

            // Serving pushes the live status word, so a change in the serving
            // cycle is already covered and the flag can drop.
            if (srv_stat) begin
                status_pend <= 1'b0;
                last_status <= stat_word;
            end else begin
                status_pend <= status_pend || status_diff;
            end

            cfg_echo_pend <= ld_cfg || (cfg_echo_pend && !srv_cfg);
            ch_echo_pend  <= ld_ch || (ch_echo_pend && !srv_ch);

            fifo_write_inc <= push;
            if (push) begin
                fifo_write_data <= push_word;
            end
        end
    end

endmodule

// File: tb/tb_fifo2core.sv
// tb/tb_fifo2core.sv - directed self-checking bench for fifo2core

module tb_fifo2core;

    logic        clk = 1'b0;
    logic        rst;
    logic        fifo_read_empty;
    logic [33:0] fifo_read_data;
    logic        fifo_read_inc;
    logic        fifo_write_full;
    logic [33:0] fifo_write_data;
    logic        fifo_write_inc;
    logic [15:0] config_out;
    logic [1:0]  channel_out;
    logic [31:0] tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] rx_data;
    logic        rx_valid;
    logic [15:0] status_in;
    logic        rx_overrun;

    always #5 clk = ~clk;

    fifo2core dut (
        .clk             (clk),
        .rst             (rst),
        .fifo_read_empty (fifo_read_empty),
        .fifo_read_data  (fifo_read_data),
        .fifo_read_inc   (fifo_read_inc),
        .fifo_write_full (fifo_write_full),
        .fifo_write_data (fifo_write_data),
        .fifo_write_inc  (fifo_write_inc),
        .config_out      (config_out),
        .channel_out     (channel_out),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .status_in       (status_in),
        .rx_overrun      (rx_overrun)
    );

    logic [33:0] dq[$];
    logic [33:0] uq[$];
    int          ucyc[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    // Downlink FIFO pop and uplink push capture, using pre-edge strobe values.
    always @(posedge clk) begin
        logic [33:0] popped;
        if (fifo_read_inc && dq.size() != 0) begin
            popped = dq.pop_front();
        end
        if (fifo_write_inc) begin
            uq.push_back(fifo_write_data);
            ucyc.push_back(cyc);
        end
        cyc++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic refresh();
        fifo_read_empty = (dq.size() == 0);
        fifo_read_data  = (dq.size() != 0) ? dq[0] : 34'd0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        refresh();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        rst             = 1'b1;
        fifo_write_full = 1'b0;
        tx_ready        = 1'b0;
        rx_data         = '0;
        rx_valid        = 1'b0;
        status_in       = '0;
        refresh();
        ticks(2);

        // Reset state
        check("rst_config",  config_out, 0);
        check("rst_channel", channel_out, 0);
        check("rst_txvalid", tx_valid, 0);
        check("rst_rdinc",   fifo_read_inc, 0);
        check("rst_wrinc",   fifo_write_inc, 0);
        check("rst_overrun", rx_overrun, 0);
        rst = 1'b0;
        tick();

        // Config command: register two edges after empty falls, then echo
        dq.push_back({2'd0, 32'h0000_A5C3});
        refresh();
        tick();
        check("cfg_pop",     fifo_read_inc, 1);
        check("cfg_early",   config_out, 0);
        tick();
        check("cfg_value",   config_out, 16'hA5C3);
        check("cfg_pop_end", fifo_read_inc, 0);
        tick();
        check("cfg_echo_inc",  fifo_write_inc, 1);
        check("cfg_echo_data", fifo_write_data, {2'd0, 32'h0000_A5C3});
        ticks(2);
        uq.delete();
        ucyc.delete();

        // Data command held by tx_ready low; a queued command waits
        dq.push_back({2'd1, 32'hDEAD_BEEF});
        dq.push_back({2'd0, 32'h0000_1111});
        refresh();
        tick();
        check("tx_pop", fifo_read_inc, 1);
        tick();
        for (int i = 0; i < 5; i++) begin
            check($sformatf("tx_hold_valid%0d", i), tx_valid, 1);
            check($sformatf("tx_hold_data%0d", i), tx_data, 32'hDEAD_BEEF);
            check($sformatf("tx_no_pop%0d", i), fifo_read_inc, 0);
            if (i < 4) tick();
        end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("tx_done_valid", tx_valid, 0);
        check("tx_done_nopop", fifo_read_inc, 0);
        tick();
        check("tx_next_pop", fifo_read_inc, 1);
        tick();
        check("tx_next_cfg", config_out, 16'h1111);
        ticks(3);
        uq.delete();
        ucyc.delete();

        // Channel command and its echo
        dq.push_back({2'd3, 32'h0000_0002});
        refresh();
        ticks(2);
        check("ch_value", channel_out, 2'd2);
        tick();
        check("ch_echo_inc",  fifo_write_inc, 1);
        check("ch_echo_data", fifo_write_data, {2'd3, 32'h0000_0002});
        ticks(2);
        uq.delete();
        ucyc.delete();

        // Receive while uplink full, then exactly one push on release
        fifo_write_full = 1'b1;
        rx_data  = 32'h1234_5678;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rx_full_nopush%0d", i), fifo_write_inc, 0);
        end
        fifo_write_full = 1'b0;
        tick();
        check("rx_push_inc",  fifo_write_inc, 1);
        check("rx_push_data", fifo_write_data, {2'd1, 32'h1234_5678});
        tick();
        check("rx_push_once", fifo_write_inc, 0);
        ticks(2);
        check("rx_push_count", uq.size(), 1);
        if (uq.size() >= 1) check("rx_push_word", uq[0], {2'd1, 32'h1234_5678});
        uq.delete();
        ucyc.delete();

        // Overrun while full, status push with bit 15, then W1C clear
        fifo_write_full = 1'b1;
        rx_valid = 1'b1;
        rx_data  = 32'hAAAA_0001;
        tick();
        check("ovr_first", rx_overrun, 0);
        rx_data = 32'hBBBB_0002;
        tick();
        rx_valid = 1'b0;
        check("ovr_set", rx_overrun, 1);
        ticks(2);
        check("ovr_full_nopush", fifo_write_inc, 0);
        fifo_write_full = 1'b0;
        ticks(4);
        check("ovr_push_count", uq.size(), 2);
        if (uq.size() >= 2) begin
            check("ovr_push_stat", uq[0], {2'd2, 32'h0000_8000});
            check("ovr_push_rx",   uq[1], {2'd1, 32'hBBBB_0002});
        end
        uq.delete();
        ucyc.delete();
        dq.push_back({2'd2, 32'h0000_8000});
        refresh();
        ticks(2);
        check("ovr_cleared", rx_overrun, 0);
        ticks(4);
        check("clr_push_count", uq.size(), 1);
        if (uq.size() >= 1) check("clr_push_stat", uq[0], {2'd2, 32'h0000_0000});
        uq.delete();
        ucyc.delete();

        // Simultaneous pending events served in priority order
        fifo_write_full = 1'b1;
        status_in = 16'h0042;
        rx_data   = 32'h0BAD_F00D;
        rx_valid  = 1'b1;
        dq.push_back({2'd0, 32'h0000_5A5A});
        refresh();
        tick();
        rx_valid = 1'b0;
        ticks(3);
        check("arb_full_nopush", fifo_write_inc, 0);
        check("arb_cfg_value",   config_out, 16'h5A5A);
        fifo_write_full = 1'b0;
        ticks(6);
        check("arb_count", uq.size(), 3);
        if (uq.size() >= 3) begin
            check("arb_first_stat", uq[0], {2'd2, 32'h0000_0042});
            check("arb_second_rx",  uq[1], {2'd1, 32'h0BAD_F00D});
            check("arb_third_cfg",  uq[2], {2'd0, 32'h0000_5A5A});
            check("arb_gap01", ucyc[1] - ucyc[0], 1);
            check("arb_gap12", ucyc[2] - ucyc[1], 1);
        end
        uq.delete();
        ucyc.delete();

        // Reset while waiting for tx_ready
        dq.push_back({2'd1, 32'hCAFE_F00D});
        refresh();
        ticks(2);
        check("rstw_txvalid_pre", tx_valid, 1);
        rst = 1'b1;
        status_in = 16'h0077;
        tick();
        check("rstw_txvalid", tx_valid, 0);
        check("rstw_txdata",  tx_data, 0);
        check("rstw_config",  config_out, 0);
        check("rstw_channel", channel_out, 0);
        check("rstw_rdinc",   fifo_read_inc, 0);
        check("rstw_wrinc",   fifo_write_inc, 0);
        tick();
        check("rstw_rdinc2",  fifo_read_inc, 0);
        check("rstw_wrinc2",  fifo_write_inc, 0);
        rst = 1'b0;
        ticks(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
